// File: rtl/spi_cmd_pkg.sv
// Shared types and constants for the SPI command controller.
package spi_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_WDATA = 3'd3,
        ST_RDATA = 3'd4,
        ST_STAT  = 3'd5,
        ST_DRAIN = 3'd6
    } spi_ctrl_state_t;

    localparam logic [7:0] CMD_WRITE  = 8'h01;
    localparam logic [7:0] CMD_READ   = 8'h02;
    localparam logic [7:0] CMD_STATUS = 8'h03;

    localparam logic [7:0] STATUS_ID_DEFAULT = 8'hA5;
    localparam logic [7:0] FILL_BYTE_DEFAULT = 8'hFF;

endpackage

// File: rtl/spi_reg_bank.sv
// NUM_REGS x 8-bit register bank: one synchronous write port, two
// combinational read ports (transmit path and display path).
module spi_reg_bank #(
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned AW       = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr_tx,
    output logic [7:0]    rdata_tx,
    input  logic [AW-1:0] raddr_disp,
    output logic [7:0]    rdata_disp
);

    logic [7:0] regs [NUM_REGS];

    // Storage: cleared on reset, otherwise written on we
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    // Read ports see pre-write contents within the writing cycle
    always_comb begin
        rdata_tx   = regs[raddr_tx];
        rdata_disp = regs[raddr_disp];
    end

endmodule

// File: rtl/spi_cmd_controller.sv
// Turns the SPI slave byte stream into register transactions and
// serves transmit bytes on request.
module spi_cmd_controller
    import spi_cmd_pkg::*;
#(
    parameter int unsigned NUM_REGS  = 4,
    parameter logic [7:0]  STATUS_ID = STATUS_ID_DEFAULT,
    parameter logic [7:0]  FILL_BYTE = FILL_BYTE_DEFAULT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cs_active,
    input  logic                        rx_valid,
    input  logic [7:0]                  rx_byte,
    input  logic                        tx_req,
    output logic [7:0]                  tx_byte,
    output logic                        tx_valid,
    input  logic [$clog2(NUM_REGS)-1:0] reg_sel,
    output logic [7:0]                  reg_out,
    output logic                        busy,
    output logic                        err,
    output logic                        frame_done
);

    localparam int unsigned AW         = $clog2(NUM_REGS);
    localparam logic [7:0]  NUM_REGS_B = 8'(NUM_REGS);

    spi_ctrl_state_t state;
    logic [AW-1:0]   addr;
    logic [7:0]      cmd_q;
    logic            cs_q;
    logic            cs_armed;
    logic            cs_rise;
    logic            cs_fall;
    logic            wr_en;
    logic [7:0]      rd_tx;
    logic [7:0]      rd_disp;

    spi_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_bank (
        .clk        (clk),
        .reset      (reset),
        .we         (wr_en),
        .waddr      (addr),
        .wdata      (rx_byte),
        .raddr_tx   (addr),
        .rdata_tx   (rd_tx),
        .raddr_disp (reg_sel),
        .rdata_disp (rd_disp)
    );

    // Frame edge detection; a rise only counts once cs has been seen low
    // after reset, so a chip-select held high through reset starts nothing.
    always_comb begin
        cs_rise = cs_active & ~cs_q & cs_armed;
        cs_fall = ~cs_active & cs_q;
        wr_en   = (state == ST_WDATA) && rx_valid;
        busy    = (state != ST_IDLE);
    end

    // Registered chip-select and the post-reset arming flag
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_q       <= 1'b0;
            cs_armed   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            cs_q       <= cs_active;
            frame_done <= cs_fall;
            if (!cs_active) begin
                cs_armed <= 1'b1;
            end
        end
    end

    // Command/address/data sequencing; the received byte is processed
    // before a coincident frame end forces IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            addr  <= '0;
            cmd_q <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cs_rise) begin
                        state <= ST_CMD;
                        err   <= 1'b0;
                    end
                end
                ST_CMD: begin
                    if (rx_valid) begin
                        if (rx_byte == CMD_WRITE || rx_byte == CMD_READ) begin
                            cmd_q <= rx_byte;
                            state <= ST_ADDR;
                        end else if (rx_byte == CMD_STATUS) begin
                            state <= ST_STAT;
                        end else begin
                            state <= ST_DRAIN;
                            err   <= 1'b1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (rx_valid) begin
                        if (rx_byte >= NUM_REGS_B) begin
                            state <= ST_DRAIN;
                            err   <= 1'b1;
                        end else begin
                            addr  <= rx_byte[AW-1:0];
                            state <= (cmd_q == CMD_READ) ? ST_RDATA : ST_WDATA;
                        end
                    end
                end
                ST_WDATA: begin
                    if (rx_valid) begin
                        addr <= addr + 1'b1;
                    end
                end
                ST_RDATA: begin
                    if (tx_req) begin
                        addr <= addr + 1'b1;
                    end
                end
                default: ;
            endcase
            if (cs_fall) begin
                state <= ST_IDLE;
            end
        end
    end

    // Transmit byte selection; tx_byte holds between requests
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_byte  <= '0;
            tx_valid <= 1'b0;
        end else begin
            tx_valid <= tx_req;
            if (tx_req) begin
                case (state)
                    ST_RDATA: tx_byte <= rd_tx;
                    ST_STAT:  tx_byte <= STATUS_ID;
                    default:  tx_byte <= FILL_BYTE;
                endcase
            end
        end
    end

    // Display path register
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_out <= '0;
        end else begin
            reg_out <= rd_disp;
        end
    end

endmodule

// File: tb/tb_spi_cmd_controller.sv
// Directed plus randomized bench for spi_cmd_controller with a
// frame-level reference model.
module tb_spi_cmd_controller;

    localparam int unsigned NUM = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cs_active = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = '0;
    logic       tx_req = 1'b0;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic [1:0] reg_sel = '0;
    logic [7:0] reg_out;
    logic       busy;
    logic       err;
    logic       frame_done;

    int checks = 0;
    int errors = 0;

    // Reference model: register contents and the bytes of the current frame
    logic [7:0] m_regs [NUM];
    logic [7:0] q [$];
    int         rd_count;
    bit         in_frame;

    spi_cmd_controller #(
        .NUM_REGS  (NUM),
        .STATUS_ID (8'hA5),
        .FILL_BYTE (8'hFF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cs_active  (cs_active),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .tx_req     (tx_req),
        .tx_byte    (tx_byte),
        .tx_valid   (tx_valid),
        .reg_sel    (reg_sel),
        .reg_out    (reg_out),
        .busy       (busy),
        .err        (err),
        .frame_done (frame_done)
    );

    always #20 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_err();
        if (q.size() >= 1 && !(q[0] inside {8'h01, 8'h02, 8'h03})) return 1'b1;
        if (q.size() >= 2 && (q[0] == 8'h01 || q[0] == 8'h02) && q[1] >= NUM) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_rx(input logic [7:0] b);
        int n;
        n = q.size();
        if (in_frame) begin
            if (n >= 2 && q[0] == 8'h01 && q[1] < NUM)
                m_regs[(int'(q[1]) + n - 2) % NUM] = b;
            q.push_back(b);
        end
    endtask

    task automatic model_tx(output logic [7:0] e);
        e = 8'hFF;
        if (in_frame && q.size() >= 1 && q[0] == 8'h03) begin
            e = 8'hA5;
        end else if (in_frame && q.size() >= 2 && q[0] == 8'h02 && q[1] < NUM) begin
            e = m_regs[(int'(q[1]) + rd_count) % NUM];
            rd_count++;
        end
    endtask

    task automatic start_frame();
        @(negedge clk);
        cs_active = 1'b1;
        q.delete();
        rd_count = 0;
        in_frame = 1'b1;
        @(negedge clk);
        check("start_busy", busy, 1);
        check("start_err_clear", err, 0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = b;
        model_rx(b);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic tx_request(input string tag);
        logic [7:0] e;
        @(negedge clk);
        tx_req = 1'b1;
        model_tx(e);
        @(negedge clk);
        tx_req = 1'b0;
        check({tag, "_valid"}, tx_valid, 1);
        check(tag, tx_byte, e);
        @(negedge clk);
        check({tag, "_valid_drop"}, tx_valid, 0);
        check({tag, "_hold"}, tx_byte, e);
    endtask

    task automatic end_frame();
        logic e;
        e = model_err();
        @(negedge clk);
        cs_active = 1'b0;
        in_frame  = 1'b0;
        @(negedge clk);
        check("end_frame_done", frame_done, 1);
        check("end_busy", busy, 0);
        check("end_err", err, e);
        @(negedge clk);
        check("end_frame_done_drop", frame_done, 0);
    endtask

    task automatic check_reg(input int sel);
        @(negedge clk);
        reg_sel = 2'(sel);
        @(negedge clk);
        check($sformatf("reg_out%0d", sel), reg_out, m_regs[sel]);
    endtask

    task automatic check_all_regs();
        for (int i = 0; i < NUM; i++) check_reg(i);
    endtask

    initial begin
        logic [7:0] c;
        int         nd;
        for (int i = 0; i < NUM; i++) m_regs[i] = '0;
        in_frame = 1'b0;
        rd_count = 0;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_tx_byte", tx_byte, 8'h00);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_reg_out", reg_out, 8'h00);

        // Write with one-cycle display latency
        @(negedge clk);
        reg_sel = 2'd2;
        start_frame();
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h3C);
        check("disp_before", reg_out, 8'h00);
        @(negedge clk);
        check("disp_after", reg_out, 8'h3C);
        end_frame();

        // Auto-increment wrap
        start_frame();
        send_byte(8'h01);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        end_frame();
        check_all_regs();

        // Preset reg1, then read back three with an early request in ADDR
        start_frame();
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h22);
        end_frame();
        start_frame();
        send_byte(8'h02);
        tx_request("rd_in_addr");
        send_byte(8'h01);
        tx_request("rd0");
        tx_request("rd1");
        tx_request("rd2");
        end_frame();

        // Status, then illegal command with ignored tail bytes
        start_frame();
        send_byte(8'h03);
        tx_request("status");
        end_frame();
        start_frame();
        send_byte(8'h7E);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h55);
        tx_request("illegal_fill");
        end_frame();
        check_all_regs();

        // Out-of-range address
        start_frame();
        send_byte(8'h01);
        send_byte(8'h09);
        send_byte(8'h66);
        tx_request("oor_fill");
        end_frame();
        check_all_regs();

        // Data byte coincident with cs falling edge still commits
        start_frame();
        send_byte(8'h01);
        send_byte(8'h00);
        @(negedge clk);
        rx_valid  = 1'b1;
        rx_byte   = 8'h5A;
        cs_active = 1'b0;
        model_rx(8'h5A);
        in_frame  = 1'b0;
        @(negedge clk);
        rx_valid = 1'b0;
        check("coinc_frame_done", frame_done, 1);
        check("coinc_busy", busy, 0);
        check_reg(0);

        // Randomized frames
        for (int f = 0; f < 24; f++) begin
            case ($urandom_range(0, 4))
                0, 1:    c = 8'h01;
                2:       c = 8'h02;
                3:       c = 8'h03;
                default: c = 8'($urandom_range(0, 255));
            endcase
            nd = $urandom_range(0, 5);
            start_frame();
            send_byte(c);
            if ($urandom_range(0, 3) == 0) tx_request("rnd_tx_early");
            send_byte(8'($urandom_range(0, 5)));
            for (int k = 0; k < nd; k++) begin
                send_byte(8'($urandom_range(0, 255)));
                if ($urandom_range(0, 1) == 1) tx_request("rnd_tx");
            end
            end_frame();
        end
        check_all_regs();

        // Reset in the middle of a write with cs held high
        start_frame();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h11);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NUM; i++) m_regs[i] = '0;
        in_frame = 1'b0;
        q.delete();
        check("mid_rst_tx_byte", tx_byte, 8'h00);
        check("mid_rst_tx_valid", tx_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_frame_done", frame_done, 0);
        check("mid_rst_reg_out", reg_out, 8'h00);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h77);
        check("post_rst_idle", busy, 0);
        check_all_regs();
        @(negedge clk);
        cs_active = 1'b0;
        repeat (2) @(negedge clk);
        start_frame();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h44);
        end_frame();
        check_all_regs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
